// File: rtl/quad_param_ctrl.sv
// Quadrature-encoder controller: synchronises and debounces the encoder pins, decodes 4x quadrature,
// divides into detents and applies saturating coarse/fine steps to a frequency or amplitude setting.
module quad_param_ctrl #(
  parameter int WIDTH             = 11,
  parameter int FREQ_MIN          = 1,
  parameter int FREQ_MAX          = 1000,
  parameter int AMP_MIN           = 0,
  parameter int AMP_MAX           = 1000,
  parameter int FREQ_INIT         = 440,
  parameter int AMP_INIT          = 500,
  parameter int SYNC_STAGES       = 2,
  parameter int DEB_CYCLES        = 4,
  parameter int COUNTS_PER_DETENT = 4,
  parameter int STEP_COARSE       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             switch,
  input  logic             coarse,
  input  logic             ch_a,
  input  logic             ch_b,
  output logic [WIDTH-1:0] freq,
  output logic [WIDTH-1:0] amp,
  output logic             freq_at_min,
  output logic             freq_at_max,
  output logic             amp_at_min,
  output logic             amp_at_max,
  output logic             step_pulse,
  output logic             err_pulse
);

  localparam int WX = WIDTH + 1;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int AW = $clog2(COUNTS_PER_DETENT + 1) + 1;
  localparam logic [CW-1:0]        DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic signed [AW-1:0] ACC_TOP  = AW'(COUNTS_PER_DETENT - 1);
  localparam logic signed [AW-1:0] ACC_BOT  = AW'(1 - COUNTS_PER_DETENT);
  localparam logic [WIDTH-1:0] F_MIN  = WIDTH'(FREQ_MIN);
  localparam logic [WIDTH-1:0] F_MAX  = WIDTH'(FREQ_MAX);
  localparam logic [WIDTH-1:0] A_MIN  = WIDTH'(AMP_MIN);
  localparam logic [WIDTH-1:0] A_MAX  = WIDTH'(AMP_MAX);
  localparam logic [WIDTH-1:0] F_INIT = WIDTH'(FREQ_INIT);
  localparam logic [WIDTH-1:0] A_INIT = WIDTH'(AMP_INIT);

  function automatic logic [1:0] quad_next(input logic [1:0] s);
    case (s)
      2'b00:   quad_next = 2'b10;
      2'b10:   quad_next = 2'b11;
      2'b11:   quad_next = 2'b01;
      default: quad_next = 2'b00;
    endcase
  endfunction

  logic [3:0]             sync_r [SYNC_STAGES];
  logic [1:0]             filt_r;
  logic [CW-1:0]          deb_cnt_r [2];
  logic [1:0]             prev_r;
  logic                   first_seen_r;
  logic                   sw_prev_r;
  logic signed [AW-1:0]   acc_r;
  logic                   step_up_r, step_dn_r, step_freq_r, step_big_r;
  logic [WIDTH-1:0]       freq_r, amp_r;
  logic                   freq_min_r, freq_max_r, amp_min_r, amp_max_r;
  logic                   step_pulse_r, err_pulse_r;

  logic                   sw_s, co_s;
  logic [1:0]             raw_ab_s;
  logic                   fwd_s, rev_s, ill_s, moved_s, sel_change_s;
  logic                   issue_up_s, issue_dn_s;
  logic signed [AW-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]       cur_s, lo_s, hi_s, inc_s, new_s, freq_nxt_s, amp_nxt_s;
  logic [WX-1:0]          sum_s, floor_s;

  assign sw_s     = sync_r[SYNC_STAGES-1][3];
  assign co_s     = sync_r[SYNC_STAGES-1][2];
  assign raw_ab_s = sync_r[SYNC_STAGES-1][1:0];

  // Synchroniser chains for {switch, coarse, ch_a, ch_b}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 4'b0000;
    end else begin
      sync_r[0] <= {switch, coarse, ch_a, ch_b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Independent debounce per channel; any agreement with the filtered level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_ab_s[i] == filt_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          filt_r[i]    <= raw_ab_s[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Decode the filtered {A,B} move and decide the accumulator update / step issue
  always_comb begin
    moved_s      = (filt_r != prev_r);
    sel_change_s = (sw_s != sw_prev_r);
    fwd_s        = 1'b0;
    rev_s        = 1'b0;
    ill_s        = 1'b0;
    issue_up_s   = 1'b0;
    issue_dn_s   = 1'b0;
    acc_nxt_s    = acc_r;
    if (moved_s && first_seen_r) begin
      if (filt_r == quad_next(prev_r))      fwd_s = 1'b1;
      else if (prev_r == quad_next(filt_r)) rev_s = 1'b1;
      else                                  ill_s = 1'b1;
    end else begin
      fwd_s = 1'b0;
    end
    // A select change wins over a completing detent so nothing lands on the newly chosen target
    if (sel_change_s || ill_s) begin
      acc_nxt_s = '0;
    end else if (fwd_s) begin
      if (acc_r == ACC_TOP) begin
        issue_up_s = 1'b1;
        acc_nxt_s  = '0;
      end else begin
        acc_nxt_s = acc_r + AW'(1);
      end
    end else if (rev_s) begin
      if (acc_r == ACC_BOT) begin
        issue_dn_s = 1'b1;
        acc_nxt_s  = '0;
      end else begin
        acc_nxt_s = acc_r - AW'(1);
      end
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Decoder history, detent accumulator and the issued-step register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r       <= 2'b00;
      first_seen_r <= 1'b0;
      sw_prev_r    <= 1'b0;
      acc_r        <= '0;
      step_up_r    <= 1'b0;
      step_dn_r    <= 1'b0;
      step_freq_r  <= 1'b0;
      step_big_r   <= 1'b0;
      err_pulse_r  <= 1'b0;
    end else begin
      prev_r       <= filt_r;
      first_seen_r <= first_seen_r | moved_s;
      sw_prev_r    <= sw_s;
      acc_r        <= acc_nxt_s;
      step_up_r    <= issue_up_s;
      step_dn_r    <= issue_dn_s;
      step_freq_r  <= sw_s;
      step_big_r   <= co_s;
      err_pulse_r  <= ill_s;
    end
  end

  // Saturating step arithmetic, one bit wider than the settings so nothing wraps
  always_comb begin
    cur_s      = step_freq_r ? freq_r : amp_r;
    lo_s       = step_freq_r ? F_MIN : A_MIN;
    hi_s       = step_freq_r ? F_MAX : A_MAX;
    inc_s      = step_big_r ? WIDTH'(STEP_COARSE) : WIDTH'(1);
    sum_s      = {1'b0, cur_s} + {1'b0, inc_s};
    floor_s    = {1'b0, lo_s} + {1'b0, inc_s};
    new_s      = cur_s;
    freq_nxt_s = freq_r;
    amp_nxt_s  = amp_r;
    if (step_up_r) begin
      if (sum_s > {1'b0, hi_s}) new_s = hi_s;
      else                      new_s = sum_s[WIDTH-1:0];
    end else if (step_dn_r) begin
      if ({1'b0, cur_s} < floor_s) new_s = lo_s;
      else                         new_s = cur_s - inc_s;
    end else begin
      new_s = cur_s;
    end
    if ((step_up_r || step_dn_r) && step_freq_r) begin
      freq_nxt_s = new_s;
    end else if (step_up_r || step_dn_r) begin
      amp_nxt_s = new_s;
    end else begin
      freq_nxt_s = freq_r;
    end
  end

  // Setting registers with their limit flags and the step pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_r       <= F_INIT;
      amp_r        <= A_INIT;
      freq_min_r   <= (F_INIT == F_MIN);
      freq_max_r   <= (F_INIT == F_MAX);
      amp_min_r    <= (A_INIT == A_MIN);
      amp_max_r    <= (A_INIT == A_MAX);
      step_pulse_r <= 1'b0;
    end else begin
      freq_r       <= freq_nxt_s;
      amp_r        <= amp_nxt_s;
      freq_min_r   <= (freq_nxt_s == F_MIN);
      freq_max_r   <= (freq_nxt_s == F_MAX);
      amp_min_r    <= (amp_nxt_s == A_MIN);
      amp_max_r    <= (amp_nxt_s == A_MAX);
      step_pulse_r <= step_up_r | step_dn_r;
    end
  end

  assign freq        = freq_r;
  assign amp         = amp_r;
  assign freq_at_min = freq_min_r;
  assign freq_at_max = freq_max_r;
  assign amp_at_min  = amp_min_r;
  assign amp_at_max  = amp_max_r;
  assign step_pulse  = step_pulse_r;
  assign err_pulse   = err_pulse_r;

endmodule

// File: tb/tb_quad_param_ctrl.sv
// Bench for quad_param_ctrl: two instances (default and near-limit init values) share one encoder;
// a table of encoder phases plus hand-written corner sequences, with a scoreboard on step_pulse.
module tb_quad_param_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, switch, coarse, ch_a, ch_b;
  logic [10:0] freq_a, amp_a, freq_b, amp_b;
  logic fmin_a, fmax_a, amin_a, amax_a, step_a, err_a;
  logic fmin_b, fmax_b, amin_b, amax_b, step_b, err_b;

  quad_param_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .switch(switch), .coarse(coarse), .ch_a(ch_a), .ch_b(ch_b),
    .freq(freq_a), .amp(amp_a), .freq_at_min(fmin_a), .freq_at_max(fmax_a),
    .amp_at_min(amin_a), .amp_at_max(amax_a), .step_pulse(step_a), .err_pulse(err_a));

  quad_param_ctrl #(.FREQ_INIT(995), .AMP_INIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .switch(switch), .coarse(coarse), .ch_a(ch_a), .ch_b(ch_b),
    .freq(freq_b), .amp(amp_b), .freq_at_min(fmin_b), .freq_at_max(fmax_b),
    .amp_at_min(amin_b), .amp_at_max(amax_b), .step_pulse(step_b), .err_pulse(err_b));

  typedef struct {
    int fa, aa, fb, ab;
  } exp_t;

  typedef struct {
    bit sw, co, fwd;
    int n;
    int fa, aa, fb, ab, steps;
  } row_t;

  exp_t sb_q[$];
  row_t rows[5];
  int m_fa, m_aa, m_fb, m_ab, m_acc;
  logic [1:0] enc_pos;
  int n_checks = 0, n_pass = 0, n_steps = 0, n_errs = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic int clamp_step(int v, bit up, int s, int lo, int hi);
    if (up) return (v + s > hi) ? hi : v + s;
    return (v - s < lo) ? lo : v - s;
  endfunction

  function automatic int flags_of(int f, int a);
    return {28'd0, f == 1, f == 1000, a == 0, a == 1000};
  endfunction

  function automatic logic [1:0] fwd_of(logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_of(logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Scoreboard: every step_pulse must match the oldest predicted result
  always @(negedge clk) begin
    exp_t e;
    if (err_a) begin
      n_errs++;
      check("err_b_tracks_a", err_b, 1);
    end
    if (step_a) begin
      n_steps++;
      check("step_b_tracks_a", step_b, 1);
      if (sb_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_freq_a", freq_a, e.fa);
        check("sb_amp_a", amp_a, e.aa);
        check("sb_freq_b", freq_b, e.fb);
        check("sb_amp_b", amp_b, e.ab);
        check("sb_flags_a", {fmin_a, fmax_a, amin_a, amax_a}, flags_of(e.fa, e.aa));
        check("sb_flags_b", {fmin_b, fmax_b, amin_b, amax_b}, flags_of(e.fb, e.ab));
      end
    end
  end

  task automatic predict_step(input bit up);
    exp_t e;
    int s;
    s = coarse ? 10 : 1;
    if (switch) begin
      m_fa = clamp_step(m_fa, up, s, 1, 1000);
      m_fb = clamp_step(m_fb, up, s, 1, 1000);
    end else begin
      m_aa = clamp_step(m_aa, up, s, 0, 1000);
      m_ab = clamp_step(m_ab, up, s, 0, 1000);
    end
    e.fa = m_fa; e.aa = m_aa; e.fb = m_fb; e.ab = m_ab;
    sb_q.push_back(e);
  endtask

  task automatic model_move(input bit fwd);
    m_acc += fwd ? 1 : -1;
    if (m_acc == 4) begin
      predict_step(1'b1);
      m_acc = 0;
    end else if (m_acc == -4) begin
      predict_step(1'b0);
      m_acc = 0;
    end
  endtask

  task automatic move(input bit fwd);
    model_move(fwd);
    enc_pos = fwd ? fwd_of(enc_pos) : rev_of(enc_pos);
    @(posedge clk); #1;
    {ch_a, ch_b} = enc_pos;
    repeat (20) @(posedge clk);
  endtask

  task automatic set_sel(input bit sw, input bit co);
    if (sw != switch) m_acc = 0;
    @(posedge clk); #1;
    switch = sw;
    coarse = co;
    repeat (10) @(posedge clk);
  endtask

  task automatic model_reset();
    m_fa = 440; m_aa = 500; m_fb = 995; m_ab = 3; m_acc = 0;
  endtask

  task automatic check_values(input string tag);
    check({tag, "_freq_a"}, freq_a, m_fa);
    check({tag, "_amp_a"}, amp_a, m_aa);
    check({tag, "_freq_b"}, freq_b, m_fb);
    check({tag, "_amp_b"}, amp_b, m_ab);
  endtask

  initial begin
    int s0, e0, lat;
    rows[0] = '{sw: 1'b1, co: 1'b0, fwd: 1'b1, n: 8, fa: 442, aa: 500, fb: 997,  ab: 3, steps: 2};
    rows[1] = '{sw: 1'b0, co: 1'b1, fwd: 1'b0, n: 4, fa: 442, aa: 490, fb: 997,  ab: 0, steps: 1};
    rows[2] = '{sw: 1'b0, co: 1'b1, fwd: 1'b0, n: 4, fa: 442, aa: 480, fb: 997,  ab: 0, steps: 1};
    rows[3] = '{sw: 1'b1, co: 1'b1, fwd: 1'b1, n: 4, fa: 452, aa: 480, fb: 1000, ab: 0, steps: 1};
    rows[4] = '{sw: 1'b1, co: 1'b0, fwd: 1'b1, n: 4, fa: 453, aa: 480, fb: 1000, ab: 0, steps: 1};

    // Encoder rests at 11 across reset: the first filtered change must not count
    rst_n = 1'b0; switch = 1'b1; coarse = 1'b0; ch_a = 1'b1; ch_b = 1'b1; enc_pos = 2'b11;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_values("reset");
    check("reset_flags_a", {fmin_a, fmax_a, amin_a, amax_a}, 0);
    check("reset_flags_b", {fmin_b, fmax_b, amin_b, amax_b}, 0);
    check("reset_pulses", {step_a, err_a, step_b, err_b}, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("post_reset_steps", n_steps, 0);
    check("post_reset_errs", n_errs, 0);

    for (int r = 0; r < 5; r++) begin
      set_sel(rows[r].sw, rows[r].co);
      s0 = n_steps;
      for (int k = 0; k < rows[r].n; k++) move(rows[r].fwd);
      check($sformatf("row%0d_freq_a", r), freq_a, rows[r].fa);
      check($sformatf("row%0d_amp_a", r), amp_a, rows[r].aa);
      check($sformatf("row%0d_freq_b", r), freq_b, rows[r].fb);
      check($sformatf("row%0d_amp_b", r), amp_b, rows[r].ab);
      check($sformatf("row%0d_steps", r), n_steps - s0, rows[r].steps);
      check($sformatf("row%0d_flags_b", r), {fmin_b, fmax_b, amin_b, amax_b},
            flags_of(rows[r].fb, rows[r].ab));
    end

    // Illegal double-bit jump, then a partial detent split by a select change
    s0 = n_steps; e0 = n_errs;
    enc_pos = ~enc_pos;
    m_acc = 0;
    @(posedge clk); #1;
    {ch_a, ch_b} = enc_pos;
    repeat (20) @(posedge clk);
    check("illegal_err_count", n_errs - e0, 1);
    check_values("illegal");
    for (int k = 0; k < 3; k++) move(1'b1);
    set_sel(1'b0, 1'b0);
    move(1'b1);
    check("select_clears_acc_steps", n_steps - s0, 0);
    check_values("select_clear");

    // Short glitches on ch_a must be filtered out completely
    s0 = n_steps; e0 = n_errs;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      ch_a = ~ch_a;
      repeat (2) @(posedge clk);
      #1;
      ch_a = ~ch_a;
      repeat (6) @(posedge clk);
    end
    check("glitch_steps", n_steps - s0, 0);
    check("glitch_errs", n_errs - e0, 0);

    // Finish a detent with one clean edge and measure the pin-to-output latency
    move(1'b1);
    move(1'b1);
    check("pre_latency_steps", n_steps - s0, 0);
    model_move(1'b1);
    enc_pos = fwd_of(enc_pos);
    @(posedge clk); #1;
    {ch_a, ch_b} = enc_pos;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (step_a && lat < 0) lat = k;
    end
    check("step_latency", lat, 8);
    check_values("latency");

    // Reset in the middle of a detent discards the partial count
    for (int k = 0; k < 3; k++) move(1'b1);
    s0 = n_steps; e0 = n_errs;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    sb_q.delete();
    #2;
    check_values("mid_reset");
    #8;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    move(1'b1);
    check("mid_reset_steps", n_steps - s0, 0);
    check("mid_reset_errs", n_errs - e0, 0);
    check_values("after_mid_reset");
    check("sb_leftover", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
